// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from imem, hands {pc, inst} to the decoder.
// Latency: inst_valid_o rises 2 cycles after a request is issued to a zero-wait memory; 1 inst / 3 cycles.
// Backpressure: holds the fetched word stable while inst_ready_i=0; one request outstanding at most.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        imem_resp_err_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_err_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] redir_pc;

   // Redirect targets are always word aligned; low bits from the branch unit are ignored.
   assign redir_pc = {redirect_pc_i[31:2], 2'b00};

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         inst_q  <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: request, wait for the response (dropping killed ones), hold for the decoder.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      inst_d  = inst_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_REQ: begin
            if (imem_req_ready_i) begin
               state_d = S_WAIT;
               // The request already went out with the old PC; its response must be discarded.
               if (redirect_valid_i) begin
                  pc_d   = redir_pc;
                  kill_d = 1'b1;
               end
            end else if (redirect_valid_i) begin
               // Memory only samples on the handshake, so the address may change freely.
               pc_d = redir_pc;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid_i) begin
               if (kill_q || redirect_valid_i) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
                  if (redirect_valid_i) begin
                     pc_d = redir_pc;
                  end
               end else begin
                  inst_d  = imem_resp_data_i;
                  err_d   = imem_resp_err_i;
                  state_d = S_HOLD;
               end
            end else if (redirect_valid_i) begin
               pc_d   = redir_pc;
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            // A redirect squashes the buffered word even if the decoder takes it this cycle.
            if (redirect_valid_i) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (inst_ready_i) begin
               pc_d    = pc_q + PC_STEP;
               cnt_d   = cnt_q + 32'd1;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // Outputs decode registered state only; everything reads as zero while reset is held.
   always_comb begin
      imem_req_valid_o = !rst && (state_q == S_REQ);
      imem_req_addr_o  = rst ? 32'd0 : pc_q;
      inst_valid_o     = !rst && (state_q == S_HOLD);
      pc_o             = rst ? 32'd0 : pc_q;
      inst_o           = rst ? 32'd0 : inst_q;
      inst_err_o       = !rst && err_q;
      fetch_cnt_o      = rst ? 32'd0 : cnt_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b0;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i = 1'b0;
   logic [31:0] imem_resp_data_i = 32'd0;
   logic        imem_resp_err_i = 1'b0;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_err_o;
   logic [31:0] fetch_cnt_o;

   fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req_valid_o  (imem_req_valid_o),
      .imem_req_ready_i  (imem_req_ready_i),
      .imem_req_addr_o   (imem_req_addr_o),
      .imem_resp_valid_i (imem_resp_valid_i),
      .imem_resp_data_i  (imem_resp_data_i),
      .imem_resp_err_i   (imem_resp_err_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_pc_i     (redirect_pc_i),
      .inst_valid_o      (inst_valid_o),
      .inst_ready_i      (inst_ready_i),
      .pc_o              (pc_o),
      .inst_o            (inst_o),
      .inst_err_o        (inst_err_o),
      .fetch_cnt_o       (fetch_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          delivered = 0;
   int          idle = 0;

   // Reference program state: the architectural next PC and delivered-instruction count.
   logic [31:0] model_pc = RESET_PC;
   logic [31:0] model_cnt = 32'd0;

   // Memory model state.
   bit          mem_pend = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'd0;

   bit          force_rst = 1'b0;
   bit          force_redir_en = 1'b0;
   logic [31:0] force_redir_pc = 32'd0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a[4:2] == 3'b001);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pc   = model_pc;
      e.inst = mem_data(model_pc);
      e.err  = mem_err(model_pc);
      e.cnt  = model_cnt;
      exp_q.push_back(e);
   endtask

   task automatic restart();
      exp_q.delete();
      push_exp();
   endtask

   // One clock cycle of stimulus: memory responder, decoder, branch unit, and the reference model.
   task automatic step(input bit rnd);
      @(negedge clk);
      rst = force_rst || (rnd && !inst_valid_o && !imem_req_valid_o && $urandom_range(0, 99) == 0);
      force_rst = 1'b0;
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
      imem_resp_err_i   = 1'($urandom_range(0, 1));
      if (rst) begin
         mem_pend = 1'b0;
      end else if (mem_pend) begin
         if (mem_cnt == 0) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_data_i  = mem_data(mem_addr);
            imem_resp_err_i   = mem_err(mem_addr);
            mem_pend = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      imem_req_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      inst_ready_i     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = $urandom;
      if (!rst && force_redir_en) begin
         redirect_valid_i = 1'b1;
         redirect_pc_i    = force_redir_pc;
         force_redir_en   = 1'b0;
      end else if (!rst && rnd && $urandom_range(0, 11) == 0) begin
         redirect_valid_i = 1'b1;
         case ($urandom_range(0, 2))
            0: redirect_pc_i = $urandom;
            1: redirect_pc_i = 32'h8000_0103;
            default: redirect_pc_i = 32'hFFFF_FFF9;
         endcase
      end
      #1;
      if (!rst && imem_req_valid_o && imem_req_ready_i) begin
         mem_pend = 1'b1;
         mem_addr = imem_req_addr_o;
         mem_cnt  = rnd ? $urandom_range(0, 2) : 0;
      end
      idle++;
      if (rst) begin
         model_pc  = RESET_PC;
         model_cnt = 32'd0;
         restart();
         idle = 0;
      end else if (redirect_valid_i) begin
         model_pc = redirect_pc_i & 32'hFFFF_FFFC;
         restart();
      end else if (inst_valid_o && inst_ready_i) begin
         model_pc  = model_pc + 32'd4;
         model_cnt = model_cnt + 32'd1;
         push_exp();
         delivered++;
         idle = 0;
      end
      if (idle > 300) begin
         chk("progress_timeout", 32'(idle), 32'd0);
         idle = 0;
      end
   endtask

   // Monitor: checks every DUT output against the scoreboard, independent of the stimulus.
   bit          prev_stall = 1'b0;
   logic [31:0] prev_pc, prev_inst;
   logic        prev_err;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         chk("reset_outputs_zero",
             {imem_req_valid_o, inst_valid_o, inst_err_o, 29'd0} | imem_req_addr_o | pc_o | inst_o | fetch_cnt_o,
             32'd0);
         prev_stall = 1'b0;
      end else begin
         if (imem_req_valid_o || inst_valid_o)
            chk("req_inst_exclusive", 32'(imem_req_valid_o && inst_valid_o), 32'd0);
         if (prev_stall) begin
            chk("stall_valid", 32'(inst_valid_o), 32'd1);
            chk("stall_pc", pc_o, prev_pc);
            chk("stall_inst", inst_o, prev_inst);
            chk("stall_err", 32'(inst_err_o), 32'(prev_err));
         end
         if (imem_req_valid_o && imem_req_ready_i && !redirect_valid_i) begin
            if (exp_q.size() == 0) chk("req_without_expect", 32'd1, 32'd0);
            else chk("req_addr", imem_req_addr_o, exp_q[0].pc);
         end
         if (inst_valid_o && inst_ready_i && !redirect_valid_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", pc_o, 32'hXXXX_XXXX);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("deliver_pc", pc_o, e.pc);
               chk("deliver_inst", inst_o, e.inst);
               chk("deliver_err", 32'(inst_err_o), 32'(e.err));
               chk("deliver_cnt", fetch_cnt_o, e.cnt);
            end
         end
         prev_stall = inst_valid_o && !inst_ready_i && !redirect_valid_i;
         prev_pc    = pc_o;
         prev_inst  = inst_o;
         prev_err   = inst_err_o;
      end
   end

   initial begin
      // Reset for a few cycles.
      for (int i = 0; i < 3; i++) begin
         force_rst = 1'b1;
         step(1'b0);
      end
      // Zero-wait memory, decoder always ready: valid on cycles 2, 5, 8; err on 8000_0004.
      for (int k = 0; k < 10; k++) begin
         step(1'b0);
         if (k == 0) chk("first_req_addr", imem_req_addr_o, RESET_PC);
         if (k < 9) chk($sformatf("latency_valid_c%0d", k), 32'(inst_valid_o),
                        32'(k == 2 || k == 5 || k == 8));
         if (k == 5) chk("err_pc", pc_o, 32'h8000_0004);
         if (k == 5) chk("err_flag", 32'(inst_err_o), 32'd1);
         if (k == 9) chk("fetch_cnt_3", fetch_cnt_o, 32'd3);
         if (k == 9) chk("addr_after_3", imem_req_addr_o, 32'h8000_000C);
      end
      // PC wrap: FFFF_FFFC then 0000_0000; low redirect bits ignored.
      force_redir_en = 1'b1;
      force_redir_pc = 32'hFFFF_FFFE;
      for (int k = 0; k < 12; k++) step(1'b0);
      chk("wrap_cnt", fetch_cnt_o, 32'd6);
      // Randomized traffic: memory stalls/latency, decoder stalls, redirects, resets.
      for (int k = 0; k < 4000; k++) step(1'b1);
      chk("enough_deliveries", 32'(delivered >= 150), 32'd1);
      @(negedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
